// File: rtl/priority_arbiter4.sv
// Four-requester arbiter with registered one-hot grant and per-grant hold limit.
// Define ROUND_ROBIN_EN for rotating priority; default build is fixed priority 3 > 2 > 1 > 0.
//
// state | meaning
// IDLE  | no owner, all grant outputs low
// GRANT | owner_q holds the resource, hcnt_q counts cycles of the current grant
module priority_arbiter4 #(
   parameter int MAX_HOLD = 8
) (
   input  logic       CLK,
   input  logic       RST_N,
   input  logic [3:0] REQ,
   output logic [3:0] GNT,
   output logic [1:0] GNT_ID,
   output logic       BUSY
);

   localparam int HW = (MAX_HOLD < 1) ? 1 : $clog2(MAX_HOLD + 1);
   localparam logic [HW-1:0] HOLD_LIM = HW'(MAX_HOLD);
   localparam logic [HW-1:0] HCNT_ONE = HW'(1);

   typedef enum logic {
      IDLE  = 1'b0,
      GRANT = 1'b1
   } state_t;

   state_t          state_q, state_nxt;
   logic [1:0]      owner_q, owner_nxt;
   logic [HW-1:0]   hcnt_q, hcnt_nxt;
   logic [3:0]      gnt_q, gnt_nxt;
   logic            busy_q, busy_nxt;
   logic            owner_req;
   logic            expire;
   logic            new_grant;
   logic [3:0]      req_masked;
   logic [3:0]      arb_vec;
   logic [1:0]      win;

   assign owner_req  = REQ[owner_q];
   assign req_masked = REQ & ~(4'b0001 << owner_q);

   // On expiry the current owner is excluded so a waiting requester gets a turn.
   always_comb begin
      expire  = 1'b0;
      arb_vec = REQ;
      if (state_q == GRANT && owner_req && MAX_HOLD != 0 && hcnt_q == HOLD_LIM) begin
         expire  = 1'b1;
         arb_vec = req_masked;
      end
   end

`ifdef ROUND_ROBIN_EN
   logic [1:0] last_q;

   function automatic logic [1:0] pick(input logic [3:0] v, input logic [1:0] last);
      logic [1:0] idx;
      logic [1:0] res;
      logic       found;
      res   = last;
      found = 1'b0;
      for (int k = 1; k <= 4; k++) begin
         idx = last + 2'(k);
         if (!found && v[idx]) begin
            res   = idx;
            found = 1'b1;
         end
      end
      return res;
   endfunction

   assign win = pick(arb_vec, last_q);

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         last_q <= 2'd3;
      end else if (new_grant) begin
         last_q <= win;
      end
   end
`else
   function automatic logic [1:0] pick(input logic [3:0] v);
      logic [1:0] res;
      res = 2'd0;
      if (v[3])      res = 2'd3;
      else if (v[2]) res = 2'd2;
      else if (v[1]) res = 2'd1;
      return res;
   endfunction

   assign win = pick(arb_vec);
`endif

   always_comb begin
      state_nxt = state_q;
      owner_nxt = owner_q;
      hcnt_nxt  = hcnt_q;
      new_grant = 1'b0;
      case (state_q)
         IDLE: begin
            if (REQ != 4'b0000) new_grant = 1'b1;
         end
         GRANT: begin
            if (!owner_req) begin
               if (REQ != 4'b0000) begin
                  new_grant = 1'b1;
               end else begin
                  state_nxt = IDLE;
                  owner_nxt = 2'd0;
                  hcnt_nxt  = '0;
               end
            end else if (expire) begin
               if (req_masked != 4'b0000) new_grant = 1'b1;
               else                       hcnt_nxt  = HCNT_ONE;
            end else if (hcnt_q != HOLD_LIM) begin
               hcnt_nxt = hcnt_q + HCNT_ONE;
            end
         end
         default: begin
            state_nxt = IDLE;
            owner_nxt = 2'd0;
            hcnt_nxt  = '0;
         end
      endcase
      if (new_grant) begin
         state_nxt = GRANT;
         owner_nxt = win;
         hcnt_nxt  = HCNT_ONE;
      end
   end

   // Outputs are precomputed from next state so they leave the block straight from flops.
   always_comb begin
      busy_nxt = (state_nxt == GRANT);
      gnt_nxt  = busy_nxt ? (4'b0001 << owner_nxt) : 4'b0000;
   end

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         state_q <= IDLE;
         owner_q <= 2'd0;
         hcnt_q  <= '0;
         gnt_q   <= 4'b0000;
         busy_q  <= 1'b0;
      end else begin
         state_q <= state_nxt;
         owner_q <= owner_nxt;
         hcnt_q  <= hcnt_nxt;
         gnt_q   <= gnt_nxt;
         busy_q  <= busy_nxt;
      end
   end

   assign GNT    = gnt_q;
   assign GNT_ID = owner_q;
   assign BUSY   = busy_q;

endmodule

// File: doc/priority_arbiter4.md
# priority_arbiter4

Four-requester bus arbiter that shares a single resource between requesters 0–3. It uses the team's highest-index-wins priority encoding to pick a winner and registers a one-hot grant. A grant is held while its requester keeps asserting, up to a configurable hold limit. The block sits in front of any shared datapath resource and drives its select and enable from `GNT`/`GNT_ID`.

## Interface
- `MAX_HOLD`, default 8: maximum consecutive cycles one grant may last while others wait; 0 = unlimited. Counter width is `$clog2(MAX_HOLD+1)`, minimum 1.
- `CLK`  in  1  clock; all state updates on the rising edge.
- `RST_N`  in  1  reset; asynchronous, active-low.
- `REQ`  in  4  level requests; bit i = requester i.
- `GNT`  out  4  registered one-hot grant; `4'b0000` when idle.
- `GNT_ID`  out  2  binary index of the current owner; `2'b00` when idle.
- `BUSY`  out  1  `|GNT`; high while any grant is active.

## Operation
- States:
  - `IDLE`: no owner.
  - `GRANT`: owner held in a 2-bit register; hold counter `HCNT` runs.
- Winner selection:
  - Default build: fixed priority, 3 > 2 > 1 > 0 (1xxx→3, 01xx→2, 001x→1, 0001→0).
  - With `ROUND_ROBIN_EN`: see Configuration.
- `IDLE`:
  - If `REQ != 0` at an edge, grant the winner, go to `GRANT`, set `HCNT = 1`.
  - Otherwise stay in `IDLE`.
- `GRANT`, evaluated at each edge in this order:
  - **Release.** Owner's `REQ` bit is 0.
    - Arbitrate among the current `REQ` with zero bubble.
    - If `REQ == 0`, go to `IDLE` and set `GNT = 0`.
  - **Expiry.** `MAX_HOLD != 0`, `HCNT == MAX_HOLD`, and the owner's `REQ` bit is still 1.
    - Arbitrate among `REQ` with the owner's bit masked.
    - If the masked vector is 0, the owner keeps the grant and `HCNT` reloads to 1.
  - **Otherwise.** Keep the owner and increment `HCNT`. `HCNT` saturates at `MAX_HOLD`; when `MAX_HOLD == 0` it never matters.
- Every new grant, including a handover to the same index after expiry, loads `HCNT = 1`. A grant therefore lasts exactly `MAX_HOLD` cycles when contended.
- Non-owner `REQ` changes during `GRANT` have no effect until release or expiry.
- `GNT`, `GNT_ID` and `BUSY` are always mutually consistent: `GNT == 1 << GNT_ID` when `BUSY`, and all zero otherwise.

## Timing
- Request-to-grant latency is 1 cycle. `REQ` sampled at edge n gives `GNT` valid after edge n.
- Release-to-regrant latency is 1 cycle with no idle gap. The owner's `REQ` falling at edge n moves `GNT` to the new winner at edge n.
- All outputs come directly from registers. There is no combinational path from `REQ` to `GNT`.
- Reset (`RST_N` low, at any time including mid-grant) takes effect immediately, without waiting for `CLK`:
  - `GNT = 0`, `GNT_ID = 0`, `BUSY = 0`.
  - State `IDLE`, `HCNT = 0`.
  - Round-robin pointer = 3.
- The first edge after `RST_N` rises samples `REQ` normally.
- `REQ` must be stable around `CLK`; it is synchronous to `CLK`.

## Configuration
- `ROUND_ROBIN_EN` defined:
  - A 2-bit pointer `LAST` holds the most recently granted index; it is 3 at reset.
  - The search order is `LAST+1`, `LAST+2`, `LAST+3`, `LAST` (mod 4), and the first set bit wins.
  - `LAST` updates on every new grant.
  - Expiry masking still applies.
- `ROUND_ROBIN_EN` undefined:
  - Fixed priority 3 > 2 > 1 > 0.
  - No pointer register exists.

## Test plan
- **Basic grant and release** (`MAX_HOLD=8`, fixed):
  - From `IDLE`, apply `REQ=4'b0110`. After the next edge: `GNT=4'b0100`, `GNT_ID=2`, `BUSY=1`.
  - Drop to `REQ=4'b0000`. After the next edge: `GNT=0`, `BUSY=0`.
- **Expiry handover** (`MAX_HOLD=4`, fixed):
  - Hold `REQ=4'b0110` constant.
  - `GNT=4'b0100` for exactly 4 cycles, then `4'b0010` for 4 cycles, then `4'b0100` again.
- **Solo hold and zero-bubble release** (`MAX_HOLD=4`):
  - `REQ=4'b1000` alone gives `GNT=4'b1000` continuously for 10+ cycles with no gap.
  - Then `REQ=4'b0001` gives `GNT=4'b0001` on the very next edge.
- **Asynchronous reset mid-grant:**
  - With `GNT=4'b0010`, pull `RST_N` low between clock edges.
  - Outputs go to 0 before the next edge, and stay 0 until release and a fresh `REQ`.
- **Round-robin rotation** (`ROUND_ROBIN_EN`, `MAX_HOLD=1`):
  - After reset, hold `REQ=4'b1111`.
  - `GNT` sequence is `0001, 0010, 0100, 1000, 0001`, one cycle each.
  - The same stimulus without the macro alternates `1000, 0100, 1000, 0100`.
- **Late arrival ignored** (`MAX_HOLD=0`, fixed):
  - Owner 1 granted; `REQ=4'b1010` arrives.
  - `GNT` stays `4'b0010` indefinitely until `REQ[1]` drops, then `GNT=4'b1000`.
